uart_receiver: RTL and testbench

Serial-to-parallel UART receiver, the receive end of the team's UART link. It consumes the 16x-oversampling tick produced by the baud rate generator. It detects the start bit, samples each bit at its midpoint, checks optional parity and the stop bit, and presents the received word to the system through a ready/acknowledge handshake. Overrun, framing and parity errors are flagged alongside the data.

---
 rtl/uart_receiver.sv | 135 +++++++++++++
 tb/tb_uart_receiver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive end: consumes a 16x baud tick, samples each bit at its midpoint,
// and hands finished words to the system through a ready/acknowledge handshake.
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clock,
  input  logic                 Reset,
  input  logic                 uartClock,
  input  logic                 RxD,
  input  logic                 RxAck,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxReady,
  output logic                 Overrun,
  output logic                 FramingError,
  output logic                 ParityError,
  output logic                 Busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t                 state, stateNext;
  logic                   rxMeta, rxs;
  logic [3:0]             tickCnt;
  logic [3:0]             bitCnt;
  logic [DATA_BITS-1:0]   shiftReg;
  logic                   parAcc, parErr, stopBit, frameDone;
  logic                   clrTick, sampleData, samplePar, sampleStop;
  logic                   tickMid, tickEnd;

  assign tickMid = uartClock && (tickCnt == 4'd7);
  assign tickEnd = uartClock && (tickCnt == 4'd15);
  assign Busy    = (state != IDLE);

  // Line synchroniser; resets to the idle (high) level
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      rxMeta <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      rxMeta <= RxD;
      rxs    <= rxMeta;
    end
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    clrTick    = 1'b0;
    sampleData = 1'b0;
    samplePar  = 1'b0;
    sampleStop = 1'b0;
    case (state)
      IDLE: if (uartClock && !rxs) begin
        stateNext = START;
        clrTick   = 1'b1;
      end
      START: if (tickMid) begin
        clrTick   = 1'b1;
        stateNext = rxs ? IDLE : DATA;
      end
      DATA: if (tickEnd) begin
        sampleData = 1'b1;
        if (bitCnt == 4'(DATA_BITS - 1)) stateNext = PARITY_EN ? PARITY : STOP;
      end
      PARITY: if (tickEnd) begin
        samplePar = 1'b1;
        stateNext = STOP;
      end
      STOP: if (tickEnd) begin
        sampleStop = 1'b1;
        stateNext  = rxs ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: if (uartClock && rxs) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Frame bookkeeping: tick/bit counters, running parity, stop sample
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      tickCnt   <= 4'd0;
      bitCnt    <= 4'd0;
      parAcc    <= 1'b0;
      parErr    <= 1'b0;
      stopBit   <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      frameDone <= sampleStop;
      if (clrTick)        tickCnt <= 4'd0;
      else if (uartClock) tickCnt <= tickCnt + 4'd1;
      if (state == START) begin
        bitCnt <= 4'd0;
        parAcc <= 1'b0;
      end else if (sampleData) begin
        bitCnt <= bitCnt + 4'd1;
        parAcc <= parAcc ^ rxs;
      end
      if (samplePar)  parErr  <= parAcc ^ rxs ^ PARITY_ODD;
      if (sampleStop) stopBit <= rxs;
    end
  end

  always_ff @(posedge clock) begin
    if (sampleData) shiftReg <= {rxs, shiftReg[DATA_BITS-1:1]};
  end

  // Delivery: a completing frame wins over a same-cycle acknowledge
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      RxData       <= '0;
      RxReady      <= 1'b0;
      Overrun      <= 1'b0;
      FramingError <= 1'b0;
      ParityError  <= 1'b0;
    end else if (frameDone) begin
      RxData       <= shiftReg;
      RxReady      <= 1'b1;
      FramingError <= ~stopBit;
      ParityError  <= parErr;
      Overrun      <= RxReady & ~RxAck;
    end else if (RxAck && RxReady) begin
      RxReady      <= 1'b0;
      Overrun      <= 1'b0;
      FramingError <= 1'b0;
      ParityError  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a no-parity instance and an even-parity
// instance, driven with tick-aligned frames (16 ticks per bit, tick every 4 clocks).
module tb_uart_receiver;

  logic       clock = 1'b0;
  logic       Reset;
  logic [1:0] divCnt = 2'd0;
  logic       uartClock;
  logic       rxdA, rxdB, ackA, ackB;
  logic [7:0] dataA, dataB;
  logic       readyA, ovrA, feA, peA, busyA;
  logic       readyB, ovrB, feB, peB, busyB;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) divCnt <= divCnt + 2'd1;
  assign uartClock = (divCnt == 2'd3);

  uart_receiver #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dutA (
    .clock(clock), .Reset(Reset), .uartClock(uartClock), .RxD(rxdA), .RxAck(ackA),
    .RxData(dataA), .RxReady(readyA), .Overrun(ovrA), .FramingError(feA),
    .ParityError(peA), .Busy(busyA));

  uart_receiver #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dutB (
    .clock(clock), .Reset(Reset), .uartClock(uartClock), .RxD(rxdB), .RxAck(ackB),
    .RxData(dataB), .RxReady(readyB), .Overrun(ovrB), .FramingError(feB),
    .ParityError(peB), .Busy(busyB));

  typedef struct {
    logic       sel;
    logic [7:0] data;
    logic       parBit;
    logic       stopBit;
    logic       expFe;
    logic       expPe;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic readOut(input logic sel, output logic [7:0] d, output logic rdy,
                         output logic ovr, output logic fe, output logic pe, output logic bsy);
    if (sel) begin d = dataB; rdy = readyB; ovr = ovrB; fe = feB; pe = peB; bsy = busyB; end
    else     begin d = dataA; rdy = readyA; ovr = ovrA; fe = feA; pe = peA; bsy = busyA; end
  endtask

  task automatic pulseAck(input logic sel);
    @(negedge clock);
    if (sel) ackB = 1'b1; else ackA = 1'b1;
    @(negedge clock);
    ackA = 1'b0;
    ackB = 1'b0;
  endtask

  // Start edge lands just before a tick edge E0: detection at E4, mid-start at E36,
  // stop sampled at E36+64*(bits after start), outputs loaded one edge later.
  task automatic sendFrame(input logic sel, input logic [7:0] data, input logic parBit,
                           input logic stopBit, input logic ackLoad, input logic chkLat);
    logic [10:0] bits;
    int nb, load;
    logic rdy;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    if (sel) begin bits[9] = parBit; bits[10] = stopBit; nb = 11; end
    else     begin bits[9] = stopBit; nb = 10; end
    load = 36 + 64 * (nb - 1) + 1;
    do @(negedge clock); while (!uartClock);
    for (int e = 0; e < nb * 64; e++) begin
      if (e > 0) @(negedge clock);
      if (sel) rxdB = bits[e/64]; else rxdA = bits[e/64];
      ackA = ackLoad && !sel && (e == load);
      rdy  = sel ? readyB : readyA;
      if (chkLat && e == load)     chk("latency_before_load", {31'd0, rdy}, 32'd0);
      if (chkLat && e == load + 1) chk("latency_at_load", {31'd0, rdy}, 32'd1);
    end
    ackA = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    logic [7:0] d;
    logic rdy, ovr, fe, pe, bsy;

    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h96, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1};

    Reset = 1'b0; rxdA = 1'b1; rxdB = 1'b1; ackA = 1'b0; ackB = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_RxData", {24'd0, dataA}, 32'd0);
    chk("reset_RxReady", {31'd0, readyA}, 32'd0);
    chk("reset_flags", {29'd0, ovrA, feA, peA}, 32'd0);
    chk("reset_Busy", {30'd0, busyA, busyB}, 32'd0);
    #2 Reset = 1'b1;
    repeat (20) @(negedge clock);

    for (int v = 0; v < 8; v++) begin
      sendFrame(vecs[v].sel, vecs[v].data, vecs[v].parBit, vecs[v].stopBit, 1'b0, 1'b1);
      rxdA = 1'b1; rxdB = 1'b1;
      repeat (16) @(negedge clock);
      readOut(vecs[v].sel, d, rdy, ovr, fe, pe, bsy);
      chk("vec_RxData", {24'd0, d}, {24'd0, vecs[v].data});
      chk("vec_RxReady", {31'd0, rdy}, 32'd1);
      chk("vec_FramingError", {31'd0, fe}, {31'd0, vecs[v].expFe});
      chk("vec_ParityError", {31'd0, pe}, {31'd0, vecs[v].expPe});
      chk("vec_Overrun", {31'd0, ovr}, 32'd0);
      chk("vec_Busy_idle", {31'd0, bsy}, 32'd0);
      pulseAck(vecs[v].sel);
      readOut(vecs[v].sel, d, rdy, ovr, fe, pe, bsy);
      chk("vec_ack_clears", {29'd0, rdy, fe, pe}, 32'd0);
    end

    // Start glitch: low for 5 ticks only
    do @(negedge clock); while (!uartClock);
    rxdA = 1'b0;
    repeat (20) @(negedge clock);
    rxdA = 1'b1;
    chk("glitch_busy_in_start", {31'd0, busyA}, 32'd1);
    repeat (30) @(negedge clock);
    chk("glitch_back_to_idle", {31'd0, busyA}, 32'd0);
    chk("glitch_no_frame", {28'd0, readyA, ovrA, feA, peA}, 32'd0);

    // Framing error followed by a two-frame break
    sendFrame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("break_RxData", {24'd0, dataA}, 32'h3C);
    chk("break_FramingError", {31'd0, feA}, 32'd1);
    chk("break_Busy_wait_idle", {31'd0, busyA}, 32'd1);
    pulseAck(1'b0);
    repeat (1280) @(negedge clock);
    chk("break_single_frame", {31'd0, readyA}, 32'd0);
    chk("break_Busy_held", {31'd0, busyA}, 32'd1);
    rxdA = 1'b1;
    repeat (12) @(negedge clock);
    chk("break_release_idle", {31'd0, busyA}, 32'd0);

    // Overrun, then acknowledge coinciding with completion
    sendFrame(1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1);
    sendFrame(1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clock);
    chk("overrun_RxData", {24'd0, dataA}, 32'h22);
    chk("overrun_flag", {31'd0, ovrA}, 32'd1);
    chk("overrun_RxReady", {31'd0, readyA}, 32'd1);
    sendFrame(1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clock);
    chk("ackload_RxData", {24'd0, dataA}, 32'h33);
    chk("ackload_RxReady", {31'd0, readyA}, 32'd1);
    chk("ackload_Overrun", {31'd0, ovrA}, 32'd0);

    // Asynchronous reset in the middle of a 0xFF frame
    do @(negedge clock); while (!uartClock);
    rxdA = 1'b0;
    repeat (64) @(negedge clock);
    rxdA = 1'b1;
    repeat (150) @(negedge clock);
    chk("midframe_busy", {31'd0, busyA}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("async_reset_RxData", {24'd0, dataA}, 32'd0);
    chk("async_reset_ctrl", {27'd0, readyA, ovrA, feA, peA, busyA}, 32'd0);
    @(negedge clock);
    #2 Reset = 1'b1;
    repeat (100) @(negedge clock);
    chk("post_reset_idle", {31'd0, busyA}, 32'd0);
    sendFrame(1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    chk("post_reset_RxData", {24'd0, dataA}, 32'h5A);
    chk("post_reset_status", {28'd0, readyA, ovrA, feA, peA}, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
